// File: rtl/csr_access_arbiter_pkg.sv
// Shared types and constants for the CSR access arbiter and its requesters.
package cei_mochila_pkg;

  // Widest address/data the bus structs carry; arbiter instances may use fewer bits.
  localparam int unsigned CSR_AW_MAX = 32;
  localparam int unsigned CSR_DW_MAX = 32;

  // Read data returned on an error or timed-out access.
  localparam logic [CSR_DW_MAX-1:0] ERR_WORD = 32'hBADCAB1E;

  // Default number of unanswered valid cycles before an access is aborted.
  localparam int unsigned CSR_ARB_TIMEOUT = 16;

  typedef enum logic [1:0] {
    CsrArbIdle   = 2'd0,
    CsrArbAccess = 2'd1,
    CsrArbResp   = 2'd2
  } csr_arb_state_e;

  typedef struct packed {
    logic                    req;
    logic                    we;
    logic [CSR_DW_MAX/8-1:0] be;
    logic [CSR_AW_MAX-1:0]   addr;
    logic [CSR_DW_MAX-1:0]   wdata;
  } obi_req_t;

  typedef struct packed {
    logic                  gnt;
    logic                  rvalid;
    logic [CSR_DW_MAX-1:0] rdata;
  } obi_resp_t;

  typedef struct packed {
    logic                    valid;
    logic                    write;
    logic [CSR_AW_MAX-1:0]   addr;
    logic [CSR_DW_MAX-1:0]   wdata;
    logic [CSR_DW_MAX/8-1:0] wstrb;
  } reg_req_t;

  typedef struct packed {
    logic                  ready;
    logic                  error;
    logic [CSR_DW_MAX-1:0] rdata;
  } reg_rsp_t;

endpackage

// File: rtl/csr_access_arbiter_picker.sv
// Round-robin picker: first requester at or after the pointer, scanning circularly.
module csr_rr_picker #(
  parameter int unsigned N = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] rr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic          found;
  logic [IW-1:0] cand;

  // Scan N candidates starting at rr_i; the first one requesting wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(rr_i) + k) % N);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/csr_access_arbiter.sv
// Arbitrates NPORTS OBI requesters onto a single register port: round-robin,
// one access in flight, bounded wait for the CSR block, error accounting.
module csr_access_arbiter
  import cei_mochila_pkg::*;
#(
  parameter int unsigned NPORTS  = 2,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = CSR_ARB_TIMEOUT,
  parameter int unsigned ERRW    = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  obi_req_t  [NPORTS-1:0] obi_req_i,
  output obi_resp_t [NPORTS-1:0] obi_resp_o,
  output reg_req_t               reg_req_o,
  input  reg_rsp_t               reg_rsp_i,
  output logic                   busy_o,
  output logic                   err_pulse_o,
  output logic [ERRW-1:0]        err_cnt_o
);

  localparam int unsigned IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int unsigned BW = DW / 8;
  // Zero-width counters are illegal, so a disabled timeout keeps one unused bit.
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] ToLast  = TW'(TIMEOUT - 1);
  localparam logic [DW-1:0] ErrData = ERR_WORD[DW-1:0];

  localparam logic [1:0] StIdle   = CsrArbIdle;
  localparam logic [1:0] StAccess = CsrArbAccess;
  localparam logic [1:0] StResp   = CsrArbResp;

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            we_q, we_d;
  logic [BW-1:0]   be_q, be_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [ERRW-1:0] err_cnt_q, err_cnt_d;

  logic [NPORTS-1:0] req_vec;
  logic [NPORTS-1:0] pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic [ERRW-1:0]   err_cnt_inc;

  // Collect the request bits for the picker.
  always_comb begin
    req_vec = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      req_vec[i] = obi_req_i[i].req;
    end
  end

  csr_rr_picker #(
    .N (NPORTS)
  ) u_picker (
    .req_i (req_vec),
    .rr_i  (rr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  assign err_cnt_inc = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;

  // Next-state logic: accept in IDLE, wait for ready or timeout in ACCESS, reply in RESP.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    idx_d     = idx_q;
    we_d      = we_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    to_cnt_d  = to_cnt_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      StIdle: begin
        if (|req_vec) begin
          state_d  = StAccess;
          idx_d    = pick_idx;
          we_d     = obi_req_i[pick_idx].we;
          be_d     = obi_req_i[pick_idx].be[BW-1:0];
          addr_d   = obi_req_i[pick_idx].addr[AW-1:0];
          wdata_d  = obi_req_i[pick_idx].wdata[DW-1:0];
          to_cnt_d = '0;
        end
      end
      StAccess: begin
        // ready is checked first so it wins over a coincident timeout.
        if (reg_rsp_i.ready) begin
          state_d = StResp;
          err_d   = reg_rsp_i.error;
          rdata_d = reg_rsp_i.error ? ErrData : reg_rsp_i.rdata[DW-1:0];
          if (reg_rsp_i.error) begin
            err_cnt_d = err_cnt_inc;
          end
        end else if ((TIMEOUT != 0) && (to_cnt_q == ToLast)) begin
          state_d   = StResp;
          err_d     = 1'b1;
          rdata_d   = ErrData;
          err_cnt_d = err_cnt_inc;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
        rr_d    = (idx_q == IW'(NPORTS - 1)) ? '0 : idx_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      rr_q      <= '0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      to_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      idx_q     <= idx_d;
      we_q      <= we_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      to_cnt_q  <= to_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Requester-side outputs: grant only while idle (and out of reset), reply only to the owner.
  always_comb begin
    obi_resp_o = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      obi_resp_o[i].gnt = (state_q == StIdle) && rst_ni && pick_gnt[i];
      if ((state_q == StResp) && (idx_q == IW'(i))) begin
        obi_resp_o[i].rvalid          = 1'b1;
        obi_resp_o[i].rdata[DW-1:0] = rdata_q;
      end
    end
  end

  // Register-port outputs driven from the latched request.
  always_comb begin
    reg_req_o               = '0;
    reg_req_o.valid         = (state_q == StAccess);
    reg_req_o.write         = we_q;
    reg_req_o.addr[AW-1:0]  = addr_q;
    reg_req_o.wdata[DW-1:0] = wdata_q;
    reg_req_o.wstrb[BW-1:0] = be_q;
  end

  assign busy_o      = (state_q != StIdle);
  assign err_pulse_o = (state_q == StResp) && err_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Scoreboard bench for csr_access_arbiter: three requesters, a scripted CSR responder,
// and a transaction-level reference model predicting grant order and replies.
module tb_csr_access_arbiter;
  import cei_mochila_pkg::*;

  localparam int unsigned NP   = 3;
  localparam int unsigned TO   = 16;
  localparam int unsigned EW   = 2;
  localparam int          EMAX = (1 << EW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  obi_req_t  [NP-1:0] obi_req;
  obi_resp_t [NP-1:0] obi_resp;
  reg_req_t           reg_req;
  reg_rsp_t           reg_rsp;
  logic               busy, err_pulse;
  logic [EW-1:0]      err_cnt;

  always #5 clk = ~clk;

  csr_access_arbiter #(
    .NPORTS  (NP),
    .AW      (32),
    .DW      (32),
    .TIMEOUT (TO),
    .ERRW    (EW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .obi_req_i   (obi_req),
    .obi_resp_o  (obi_resp),
    .reg_req_o   (reg_req),
    .reg_rsp_i   (reg_rsp),
    .busy_o      (busy),
    .err_pulse_o (err_pulse),
    .err_cnt_o   (err_cnt)
  );

  // One requester transaction together with how the CSR block will answer it.
  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;    // ACCESS cycles without ready before ready
    bit          tout;   // CSR never answers
    bit          err;
    logic [31:0] rdata;
  } item_t;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    bit          err;
    int          cnt;
    int          lat;    // gnt cycle -> rvalid cycle
  } exp_t;

  item_t stage_q[NP][$];
  item_t port_q[NP][$];
  item_t plan_q[$];
  exp_t  exp_q[$];
  int    gnt_exp_q[$];
  int    gnt_cyc_q[NP][$];

  int rr_m = 0;
  int errcnt_m = 0;
  int cyc = 0;
  int n_pass = 0;
  int n_tot = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  function automatic item_t mk(logic we, logic [3:0] be, logic [31:0] addr, logic [31:0] wdata,
                               int lat, bit tout, bit err, logic [31:0] rdata);
    item_t it;
    it.we = we; it.be = be; it.addr = addr; it.wdata = wdata;
    it.lat = lat; it.tout = tout; it.err = err; it.rdata = rdata;
    return it;
  endfunction

  function automatic item_t rand_item();
    item_t it;
    it.we    = 1'($urandom_range(0, 1));
    it.be    = 4'($urandom_range(1, 15));
    it.addr  = $urandom & 32'h0000_0FFC;
    it.wdata = $urandom;
    it.lat   = $urandom_range(0, 5);
    it.tout  = ($urandom_range(0, 9) == 0);
    it.err   = ($urandom_range(0, 4) == 0);
    it.rdata = $urandom;
    return it;
  endfunction

  // Reference model: with every staged request pending, grants follow the pointer
  // circularly; the pointer moves past each winner. Predicts order and replies.
  task automatic issue();
    int    pos[NP];
    int    p;
    bit    any;
    bit    bad;
    item_t it;
    exp_t  e;
    for (int i = 0; i < NP; i++) pos[i] = 0;
    while (1) begin
      any = 0;
      p = 0;
      for (int k = 0; k < NP; k++) begin
        p = (rr_m + k) % NP;
        if (pos[p] < stage_q[p].size()) begin
          any = 1;
          break;
        end
      end
      if (!any) break;
      it = stage_q[p][pos[p]];
      pos[p]++;
      bad = it.tout || it.err;
      if (bad && errcnt_m < EMAX) errcnt_m++;
      e.port  = p;
      e.rdata = bad ? ERR_WORD : it.rdata;
      e.err   = bad;
      e.cnt   = errcnt_m;
      e.lat   = it.tout ? TO + 1 : it.lat + 2;
      gnt_exp_q.push_back(p);
      plan_q.push_back(it);
      exp_q.push_back(e);
      rr_m = (p + 1) % NP;
    end
    for (int i = 0; i < NP; i++) begin
      foreach (stage_q[i][j]) port_q[i].push_back(stage_q[i][j]);
      stage_q[i].delete();
    end
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && (plan_q.size() == 0) && (gnt_exp_q.size() == 0) && !busy &&
             (port_q[0].size() == 0) && (port_q[1].size() == 0) && (port_q[2].size() == 0);
    end
    check("drain within budget", done, 1);
    if (!done) begin
      exp_q.delete(); plan_q.delete(); gnt_exp_q.delete();
      for (int i = 0; i < NP; i++) begin port_q[i].delete(); gnt_cyc_q[i].delete(); end
    end
  endtask

  // Requesters: hold req until granted, then present the next queued transaction.
  initial begin
    bit taken[NP];
    logic [NP-1:0] gvec;
    obi_req = '0;
    forever begin
      @(negedge clk);
      gvec = '0;
      for (int p = 0; p < NP; p++) begin
        gvec[p]  = obi_resp[p].gnt;
        taken[p] = rst_n && obi_req[p].req && obi_resp[p].gnt;
      end
      if (gvec != '0) begin
        check("gnt onehot", $countones(gvec), 1);
        check("gnt only when idle", busy, 0);
      end
      for (int p = 0; p < NP; p++) begin
        if (taken[p]) begin
          gnt_cyc_q[p].push_back(cyc);
          check("grant pending", gnt_exp_q.size() != 0, 1);
          if (gnt_exp_q.size() != 0) check("grant order", p, gnt_exp_q.pop_front());
        end
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (taken[p] && port_q[p].size() != 0) void'(port_q[p].pop_front());
        if (port_q[p].size() != 0) begin
          obi_req[p].req   = 1'b1;
          obi_req[p].we    = port_q[p][0].we;
          obi_req[p].be    = port_q[p][0].be;
          obi_req[p].addr  = port_q[p][0].addr;
          obi_req[p].wdata = port_q[p][0].wdata;
        end else begin
          obi_req[p] = '0;
        end
      end
    end
  end

  // CSR responder: plays back the planned answer for each access in grant order.
  initial begin
    bit    active;
    int    vcyc;
    item_t cur;
    active = 0;
    vcyc = 0;
    cur = mk(0, 4'h0, 32'h0, 32'h0, 0, 1, 0, 32'h0);
    reg_rsp = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 0;
        reg_rsp = '0;
      end else if (reg_req.valid) begin
        if (!active) begin
          active = 1;
          vcyc = 0;
          check("reg access planned", plan_q.size() != 0, 1);
          if (plan_q.size() != 0) cur = plan_q.pop_front();
          else cur = mk(0, 4'h0, 32'h0, 32'h0, 0, 1, 0, 32'h0);
        end
        check("reg fields", {reg_req.write, reg_req.wstrb, reg_req.addr, reg_req.wdata},
              {cur.we, cur.be, cur.addr, cur.wdata});
        if (!cur.tout && vcyc == cur.lat) begin
          reg_rsp.ready = 1'b1;
          reg_rsp.error = cur.err;
          reg_rsp.rdata = cur.rdata;
        end else begin
          reg_rsp.ready = 1'b0;
          reg_rsp.error = 1'($urandom_range(0, 1));
          reg_rsp.rdata = $urandom;
        end
        vcyc++;
      end else begin
        if (active) check("valid cycles", vcyc, cur.tout ? TO : cur.lat + 1);
        active = 0;
        reg_rsp.ready = 1'b0;
        reg_rsp.error = 1'b0;
      end
    end
  end

  // Monitor: every rvalid pops the oldest expectation and is compared against it.
  initial begin
    bit   any_rv;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        any_rv = 0;
        for (int p = 0; p < NP; p++) begin
          if (obi_resp[p].rvalid) begin
            any_rv = 1;
            check("rvalid expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("rvalid port", p, e.port);
              check("rdata", obi_resp[p].rdata, e.rdata);
              check("err pulse", err_pulse, e.err);
              check("err count", err_cnt, e.cnt);
              check("busy in resp", busy, 1);
              check("gnt recorded", gnt_cyc_q[p].size() != 0, 1);
              if (gnt_cyc_q[p].size() != 0) check("gnt->rvalid latency",
                                                  cyc - gnt_cyc_q[p].pop_front(), e.lat);
            end
          end
        end
        if (!any_rv && err_pulse) check("err pulse without rvalid", err_pulse, 0);
      end
    end
  end

  initial begin
    logic [NP-1:0] gv, rv;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    gv = '0; rv = '0;
    for (int p = 0; p < NP; p++) begin gv[p] = obi_resp[p].gnt; rv[p] = obi_resp[p].rvalid; end
    check("reset busy", busy, 0);
    check("reset err pulse", err_pulse, 0);
    check("reset err count", err_cnt, 0);
    check("reset reg req", reg_req, 0);
    check("reset gnt", gv, 0);
    check("reset rvalid", rv, 0);
    rst_n = 1'b1;

    // All ports requesting from reset: 0,1,2,0,1,2.
    for (int p = 0; p < NP; p++)
      for (int j = 0; j < 2; j++)
        stage_q[p].push_back(mk(0, 4'hF, 32'h100 + 32'(p * 16 + j * 4), 32'h0, 0, 0, 0,
                                32'hA000_0100 + 32'(p * 16 + j * 4)));
    issue();
    wait_idle(200);

    // Single read, port 0, ready on the third valid cycle.
    stage_q[0].push_back(mk(0, 4'hF, 32'h10, 32'h0, 2, 0, 0, 32'h1234_5678));
    issue();
    wait_idle(100);
    check("err count after clean read", err_cnt, 0);

    // CSR never answers: timeout.
    stage_q[0].push_back(mk(0, 4'hF, 32'h20, 32'h0, 0, 1, 0, 32'h0));
    issue();
    wait_idle(100);
    check("err count after timeout", err_cnt, 1);

    // Write with partial strobe answered by ready+error.
    stage_q[2].push_back(mk(1, 4'b0011, 32'h30, 32'hCAFE_F00D, 1, 0, 1, 32'h5555_AAAA));
    issue();
    wait_idle(100);

    // Five more errors: counter saturates.
    for (int j = 0; j < 5; j++)
      stage_q[1].push_back(mk(1, 4'hF, 32'h40 + 32'(j * 4), $urandom, j % 3, 0, 1, $urandom));
    issue();
    wait_idle(200);
    check("err count saturated", err_cnt, EMAX);

    // ready on the final timeout cycle wins.
    stage_q[0].push_back(mk(0, 4'hF, 32'h50, 32'h0, TO - 1, 0, 0, 32'h0BAD_F00D));
    issue();
    wait_idle(100);

    // Reset mid-ACCESS: no reply for the aborted access, pointer back to 0.
    stage_q[2].push_back(mk(0, 4'hF, 32'h60, 32'h0, 0, 1, 0, 32'h0));
    issue();
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        seen = reg_req.valid;
      end
      check("valid before reset", seen, 1);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    plan_q.delete();
    for (int i = 0; i < NP; i++) gnt_cyc_q[i].delete();
    @(negedge clk);
    check("valid dropped by reset", reg_req.valid, 0);
    check("busy dropped by reset", busy, 0);
    rst_n = 1'b1;
    rr_m = 0;
    errcnt_m = 0;
    repeat (20) @(negedge clk);
    stage_q[1].push_back(mk(0, 4'hF, 32'h70, 32'h0, 1, 0, 0, 32'h7777_0001));
    stage_q[2].push_back(mk(0, 4'hF, 32'h74, 32'h0, 0, 0, 0, 32'h7777_0002));
    issue();
    wait_idle(100);

    // Randomised batches.
    for (int b = 0; b < 12; b++) begin
      for (int p = 0; p < NP; p++) begin
        int n;
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++) stage_q[p].push_back(rand_item());
      end
      issue();
      wait_idle(600);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
